// File: rtl/fb_refresh_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fb_refresh_arbiter
// Brief    : Shares the framebuffer port between host writes and a refresh
//            engine that transposes 8x8 tiles into page-ordered OLED bytes.
// Revision : 1.0 - initial release
// ============================================================================
module fb_refresh_arbiter #(
    parameter int H_PIXELS       = 128,
    parameter int V_PIXELS       = 64,
    parameter int MAX_HOST_BURST = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       busy,
    output logic       frame_done,
    input  logic       host_req,
    input  logic [7:0] host_xpos,
    input  logic [7:0] host_ypos,
    input  logic [7:0] host_din,
    output logic       host_ack,
    output logic       fb_we,
    output logic       fb_re,
    output logic [7:0] fb_xpos,
    output logic [7:0] fb_ypos,
    output logic [7:0] fb_din,
    input  logic [7:0] fb_dout,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready
);

    localparam logic [4:0] c_LAST_GROUP = 5'(H_PIXELS / 8 - 1);
    localparam logic [4:0] c_LAST_PAGE  = 5'(V_PIXELS / 8 - 1);
    localparam logic [3:0] c_MAX_BURST  = 4'(MAX_HOST_BURST);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EMIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  page_q, page_d;
    logic [4:0]  group_q, group_d;
    logic [3:0]  rd_idx_q, rd_idx_d;
    logic        cap_q, cap_d;
    logic [2:0]  cap_row_q, cap_row_d;
    logic [2:0]  col_q, col_d;
    logic [3:0]  burst_q, burst_d;
    logic [7:0]  rows_q [0:7];

    logic w_rd_pending;
    logic w_host_grant;
    logic w_rd_grant;
    logic w_emit;
    logic w_unused;

    assign w_unused = ^host_xpos[2:0];

    // Host wins unless it has used up its burst while a read waits; nothing is granted during reset.
    assign w_rd_pending = (state_q == S_READ) && !rd_idx_q[3];
    assign w_host_grant = !rst && host_req && (burst_q < c_MAX_BURST);
    assign w_rd_grant   = !rst && w_rd_pending && !w_host_grant;
    assign w_emit       = (state_q == S_EMIT);

    assign fb_we      = w_host_grant;
    assign fb_re      = w_rd_grant;
    assign host_ack   = w_host_grant;
    assign out_valid  = w_emit;
    assign busy       = (state_q == S_READ) || (state_q == S_EMIT);
    assign frame_done = (state_q == S_DONE);

    always_comb begin
        fb_xpos = 8'd0;
        fb_ypos = 8'd0;
        fb_din  = 8'd0;
        if (w_host_grant) begin
            fb_xpos = {host_xpos[7:3], 3'b000};
            fb_ypos = host_ypos;
            fb_din  = host_din;
        end else if (w_rd_grant) begin
            fb_xpos = {group_q, 3'b000};
            fb_ypos = {page_q, rd_idx_q[2:0]};
        end
    end

    // Column k of the tile: bit r comes from row r, pixel k counted from the left (bit 7).
    for (genvar r = 0; r < 8; r++) begin : g_col_bit
        assign out_data[r] = w_emit & rows_q[r][~col_q];
    end

    always_comb begin
        burst_d = burst_q;
        if (!w_rd_pending || w_rd_grant) begin
            burst_d = 4'd0;
        end else if (w_host_grant) begin
            burst_d = burst_q + 4'd1;
        end
    end

    always_comb begin
        state_d   = state_q;
        page_d    = page_q;
        group_d   = group_q;
        rd_idx_d  = rd_idx_q;
        col_d     = col_q;
        cap_d     = w_rd_grant;
        cap_row_d = rd_idx_q[2:0];
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_READ;
                    page_d   = 5'd0;
                    group_d  = 5'd0;
                    rd_idx_d = 4'd0;
                end
            end
            S_READ: begin
                if (w_rd_grant) begin
                    rd_idx_d = rd_idx_q + 4'd1;
                end
                if (cap_q && (cap_row_q == 3'd7)) begin
                    state_d = S_EMIT;
                    col_d   = 3'd0;
                end
            end
            S_EMIT: begin
                if (out_ready) begin
                    col_d = col_q + 3'd1;
                    if (col_q == 3'd7) begin
                        rd_idx_d = 4'd0;
                        if (group_q == c_LAST_GROUP) begin
                            group_d = 5'd0;
                            if (page_q == c_LAST_PAGE) begin
                                state_d = S_DONE;
                            end else begin
                                page_d  = page_q + 5'd1;
                                state_d = S_READ;
                            end
                        end else begin
                            group_d = group_q + 5'd1;
                            state_d = S_READ;
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            page_q    <= 5'd0;
            group_q   <= 5'd0;
            rd_idx_q  <= 4'd0;
            cap_q     <= 1'b0;
            cap_row_q <= 3'd0;
            col_q     <= 3'd0;
            burst_q   <= 4'd0;
            for (int i = 0; i < 8; i++) begin
                rows_q[i] <= 8'd0;
            end
        end else begin
            state_q   <= state_d;
            page_q    <= page_d;
            group_q   <= group_d;
            rd_idx_q  <= rd_idx_d;
            cap_q     <= cap_d;
            cap_row_q <= cap_row_d;
            col_q     <= col_d;
            burst_q   <= burst_d;
            if (cap_q) begin
                rows_q[cap_row_q] <= fb_dout;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fb_refresh_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fb_refresh_arbiter
// Brief    : Self-checking bench; framebuffer model plus pixel-level page reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fb_refresh_arbiter;

    localparam int H      = 128;
    localparam int V      = 64;
    localparam int MAXB   = 4;
    localparam int NBYTES = H * V / 8;

    logic       clk = 1'b0;
    logic       rst, start, host_req, out_ready;
    logic [7:0] host_xpos, host_ypos, host_din;
    logic       busy, frame_done, host_ack, fb_we, fb_re, out_valid;
    logic [7:0] fb_xpos, fb_ypos, fb_din, fb_dout, out_data;

    always #5 clk = ~clk;

    fb_refresh_arbiter #(.H_PIXELS(H), .V_PIXELS(V), .MAX_HOST_BURST(MAXB)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .frame_done(frame_done),
        .host_req(host_req), .host_xpos(host_xpos), .host_ypos(host_ypos),
        .host_din(host_din), .host_ack(host_ack), .fb_we(fb_we), .fb_re(fb_re),
        .fb_xpos(fb_xpos), .fb_ypos(fb_ypos), .fb_din(fb_din), .fb_dout(fb_dout),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
    );

    // Single-port framebuffer: read data appears the cycle after fb_re and holds.
    logic [7:0] mem [0:V-1][0:H/8-1];
    logic       mem_clr;
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int y = 0; y < V; y++)
                for (int x = 0; x < H / 8; x++) mem[y][x] <= 8'h00;
        end else if (fb_we) begin
            mem[fb_ypos[5:0]][fb_xpos[6:3]] <= fb_din;
        end
        if (rst) fb_dout <= 8'h00;
        else if (fb_re) fb_dout <= mem[fb_ypos[5:0]][fb_xpos[6:3]];
    end

    // Intended image, written only by the bench when it issues host writes.
    logic [7:0] img [0:V-1][0:H/8-1];

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] got [$];
    int n_done, done_at, last_hs, first_v, stab_err, excl_err, burst_err, busy_err;
    int n_re, stall_cycles;
    logic busy0, busy1, ack0;

    typedef struct {
        int         y;
        int         xb;
        logic [7:0] d;
        int         idx;
        logic [7:0] eb;
    } vec_t;
    vec_t tbl [0:5];

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Page byte n: page n/H, column n%H; bit r is the pixel at (column, 8*page + r).
    function automatic logic [7:0] exp_byte(input int n);
        int p, col;
        logic [7:0] b, px;
        p = n / H;
        col = n % H;
        for (int r = 0; r < 8; r++) begin
            px   = img[8 * p + r][col / 8];
            b[r] = px[7 - (col % 8)];
        end
        return b;
    endfunction

    function automatic longint got_at(input int idx);
        if (idx < got.size()) return longint'(got[idx]);
        return -1;
    endfunction

    task automatic host_write(input int y, input int xb, input logic [7:0] d);
        bit ok;
        ok        = 1'b0;
        host_req  = 1'b1;
        host_xpos = 8'(xb * 8 + int'($urandom_range(0, 7)));
        host_ypos = 8'(y);
        host_din  = d;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk);
            if (host_ack) ok = 1'b1;
            @(posedge clk); #1;
        end
        host_req = 1'b0;
        img[y][xb] = d;
        if (!ok) chk("host_ack_timeout", 0, 1);
    endtask

    // Starts a frame and watches it cycle by cycle; returns at posedge+1.
    task automatic run_frame(input int rmode, input bit flood, input bit coack,
                             input int stop_at, input bit pulses);
        int run, hold, post;
        bit grp_start, held, prev_stall;
        logic [7:0] prev_data;
        got.delete();
        n_done = 0; done_at = -1; last_hs = -1; first_v = -1;
        stab_err = 0; excl_err = 0; burst_err = 0; busy_err = 0; n_re = 0; stall_cycles = 0;
        run = 0; hold = 0; post = 0; grp_start = 1'b1; held = 1'b0; prev_stall = 1'b0;
        prev_data = 8'h00;
        start = 1'b1; out_ready = 1'b1; host_req = flood | coack;
        for (int cycles = 0; cycles < 30000; cycles++) begin
            @(negedge clk);
            if (cycles == 0) begin busy0 = busy; ack0 = host_ack; end
            if (cycles == 1) busy1 = busy;
            if (fb_we && fb_re) excl_err++;
            if (prev_stall) begin
                stall_cycles++;
                if (!out_valid || out_data != prev_data) stab_err++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (out_valid && first_v < 0) first_v = cycles;
            if (out_valid) grp_start = 1'b1;
            if (fb_re) begin
                n_re++;
                if (flood && ((grp_start && run < MAXB) || (!grp_start && run != MAXB)))
                    burst_err++;
                run = 0;
                grp_start = 1'b0;
            end else if (host_ack) begin
                run++;
            end
            if (out_valid && out_ready) begin got.push_back(out_data); last_hs = cycles; end
            if (frame_done) begin n_done++; done_at = cycles; end
            if (stop_at > 0 && got.size() == stop_at) break;
            if (done_at >= 0) begin
                if (busy) busy_err++;
                post++;
                if (post > 4) break;
            end
            @(posedge clk); #1;
            start = pulses && (cycles == 49 || cycles == 699);
            if (!flood) host_req = 1'b0;
            if (rmode == 2 && !held && got.size() == 300) begin hold = 10; held = 1'b1; end
            if (hold > 0) begin out_ready = 1'b0; hold--; end
            else if (rmode == 1) out_ready = ($urandom_range(0, 3) != 0);
            else out_ready = 1'b1;
        end
        @(posedge clk); #1;
        start = 1'b0; host_req = 1'b0; out_ready = 1'b1;
    endtask

    task automatic check_frame(input string tag, input bit lat);
        int mism, first;
        mism = 0; first = -1;
        for (int i = 0; i < got.size() && i < NBYTES; i++) begin
            if (got[i] !== exp_byte(i)) begin
                mism++;
                if (first < 0) first = i;
            end
        end
        chk({tag, " byte_count"}, got.size(), NBYTES);
        chk($sformatf("%s stream_mismatches(first_bad=%0d)", tag, first), mism, 0);
        chk({tag, " frame_done_pulses"}, n_done, 1);
        chk({tag, " done_minus_last_handshake"}, done_at - last_hs, 1);
        chk({tag, " busy_at_or_after_done"}, busy_err, 0);
        chk({tag, " we_re_overlap"}, excl_err, 0);
        chk({tag, " stall_instability"}, stab_err, 0);
        chk({tag, " refresh_reads"}, n_re, NBYTES);
        if (lat) begin
            chk({tag, " start_to_valid"}, first_v, 10);
            chk({tag, " busy_in_start_cycle"}, busy0, 0);
            chk({tag, " busy_after_start"}, busy1, 1);
        end
    endtask

    initial begin
        #(10 * 150000);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // y, xbyte, data, checked byte index, expected page byte
        tbl[0] = '{0,  0,  8'h80, 0,    8'h01};
        tbl[1] = '{3,  0,  8'hFF, 0,    8'h08};
        tbl[2] = '{3,  0,  8'hFF, 7,    8'h08};
        tbl[3] = '{63, 15, 8'h01, 1023, 8'h80};
        tbl[4] = '{10, 2,  8'h40, 145,  8'h04};
        tbl[5] = '{0,  0,  8'h01, 7,    8'h01};

        rst = 1'b1; start = 1'b0; host_req = 1'b0; out_ready = 1'b0;
        host_xpos = 8'h00; host_ypos = 8'h00; host_din = 8'h00; mem_clr = 1'b1;
        for (int y = 0; y < V; y++)
            for (int x = 0; x < H / 8; x++) img[y][x] = 8'h00;
        repeat (3) @(posedge clk);
        #1 mem_clr = 1'b0;
        @(negedge clk);
        chk("reset_outputs_nonzero", longint'(|{busy, frame_done, host_ack, fb_we, fb_re,
            out_valid, out_data, fb_xpos, fb_ypos, fb_din}), 0);
        @(posedge clk); #1;
        rst = 1'b0; out_ready = 1'b1;

        for (int v = 0; v < 6; v++) begin
            host_write(tbl[v].y, tbl[v].xb, tbl[v].d);
            run_frame(0, 1'b0, 1'b0, 0, 1'b0);
            chk($sformatf("vec%0d byte%0d", v, tbl[v].idx), got_at(tbl[v].idx), tbl[v].eb);
            check_frame($sformatf("vec%0d", v), 1'b1);
            host_write(tbl[v].y, tbl[v].xb, 8'h00);
        end

        for (int y = 0; y < V; y++)
            for (int x = 0; x < H / 8; x++) host_write(y, x, 8'($urandom));

        run_frame(1, 1'b0, 1'b0, 0, 1'b0);
        check_frame("random_ready", 1'b1);

        run_frame(2, 1'b0, 1'b0, 0, 1'b0);
        check_frame("ready_hold", 1'b1);
        chk("ready_hold stalled_cycles", stall_cycles, 10);

        host_xpos = 8'd24; host_ypos = 8'd5; host_din = img[5][3];
        run_frame(0, 1'b1, 1'b0, 0, 1'b0);
        check_frame("host_flood", 1'b0);
        chk("host_flood burst_pattern_errors", burst_err, 0);

        run_frame(0, 1'b0, 1'b0, 100, 1'b0);
        chk("abort handshakes_before_reset", got.size(), 100);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("abort outputs_nonzero", longint'(|{busy, frame_done, host_ack, fb_we, fb_re,
            out_valid, out_data, fb_xpos, fb_ypos, fb_din}), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        run_frame(1, 1'b0, 1'b0, 0, 1'b0);
        chk("after_abort byte0", got_at(0), exp_byte(0));
        check_frame("after_abort", 1'b1);

        run_frame(0, 1'b0, 1'b0, 0, 1'b1);
        check_frame("start_while_busy", 1'b1);

        host_xpos = 8'd16; host_ypos = 8'd1; host_din = 8'h5A;
        img[1][2] = 8'h5A;
        run_frame(0, 1'b0, 1'b1, 0, 1'b0);
        chk("start_with_host ack_same_cycle", ack0, 1);
        check_frame("start_with_host", 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fb_refresh_arbiter.md
Name: fb_refresh_arbiter

Overview:
Owns the single port of framebuffer_monochrome (128x64, 1 bpp, 8 horizontal pixels per byte) and shares it between a host pixel-writer and a refresh engine. On a start pulse, the refresh engine reads the whole frame and transposes each 8x8 tile into SSD1306-style page bytes (8 vertical pixels per byte). It streams 1024 bytes to the OLED transport over valid/ready. Host writes keep priority, with a bounded burst so refresh cannot starve.

Parameters:
H_PIXELS, 128, horizontal resolution; multiple of 8
V_PIXELS, 64, vertical resolution; multiple of 8
MAX_HOST_BURST, 4, max consecutive host grants while refresh has a read pending; range 1..15

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse; begins a frame refresh when idle
busy  out  1  high from the cycle after an accepted start until frame_done
frame_done  out  1  one-cycle pulse after the last byte handshake
host_req  in  1  host write request; held until host_ack
host_xpos  in  8  host pixel x (byte-aligned; bits [2:0] ignored)
host_ypos  in  8  host row
host_din  in  8  host byte; bit7 = leftmost pixel
host_ack  out  1  one-cycle pulse in the cycle the write is issued
fb_we  out  1  framebuffer write enable
fb_re  out  1  framebuffer read enable
fb_xpos  out  8  framebuffer x (always a multiple of 8)
fb_ypos  out  8  framebuffer row
fb_din  out  8  framebuffer write data
fb_dout  in  8  framebuffer read data; valid the cycle after fb_re, held otherwise
out_data  out  8  page byte; bit0 = top row of the page
out_valid  out  1  byte available
out_ready  in  1  consumer accepts when valid&ready

Behaviour:
- Reset: every output is 0. FSM goes to IDLE. All counters are cleared.
- fb_we and fb_re are never high in the same cycle. fb_din/fb_xpos/fb_ypos are combinational from the granted source.
- Arbitration is evaluated every cycle:
  - With host_req high and burst count < MAX_HOST_BURST: grant host (fb_we=1, host_ack=1).
  - Otherwise, if the refresh engine has a read pending: issue the read (fb_re=1).
  - Burst count increments on each host grant issued while a refresh read is pending. It clears on any refresh read or when no read is pending.
- Host writes are accepted in every FSM state, including IDLE.
- FSM states:
  - IDLE: start -> READ with page p=0, group g=0. start is ignored in any other state.
  - READ: issue 8 reads at fb_xpos=8g, fb_ypos=8p+r, r=0..7. Capture fb_dout into row register r one cycle after each issued read. A read that loses arbitration retries the same r next cycle. After the 8th capture -> EMIT.
  - EMIT: out_valid=1 and out_data = column byte k (k=0..7), where bit r of out_data = rowreg[r][7-k]. k advances only on handshake. out_data/out_valid are stable while out_ready=0. After the handshake with k=7: advance g; g wraps 15->0 and increments p. Then -> READ, or -> DONE after p=7,g=15.
  - DONE: frame_done=1 for one cycle, busy=0 -> IDLE.
- No refresh reads are requested during EMIT; the host has the port freely.
- Output order is page 0 columns 0..127, then page 1, ... page 7. Total 1024 bytes.
- Host writes landing mid-frame are allowed (tearing accepted). Bytes already captured are not re-read.
- rst mid-frame aborts immediately: no frame_done, no partial byte. The next start begins at page 0, column 0.
- Latency: start to first out_valid is 10 cycles with no host traffic (1 cycle to enter READ, 8 reads, 1 capture).

Test Plan:
1. FB all zero except row 0, xpos 0 = 0x80; start, out_ready=1 -> byte 0 = 0x01, bytes 1..1023 = 0x00; frame_done one cycle after the 1024th handshake; busy low after.
2. Row 3 at xpos 0 = 0xFF, rest zero -> bytes 0..7 = 0x08, all others 0x00. Row 63 at xpos 120 = 0x01 -> byte 1023 = 0x80.
3. out_ready low for 10 cycles mid-EMIT -> out_valid held high, out_data unchanged; the full 1024-byte sequence matches the reference model with no loss or duplication.
4. host_req held high through the frame, MAX_HOST_BURST=4 -> during READ, fb_re on exactly 1 of every 5 cycles; host_ack on the other 4; frame completes with correct data for untouched tiles.
5. rst asserted after 100 handshakes -> next cycle all outputs 0; a new start yields byte 0 = page 0, column 0 value.
6. start pulsed while busy -> ignored (byte count stays 1024, one frame_done). host_req and start in the same IDLE cycle -> host_ack that cycle and busy next cycle.
